// File: rtl/uno_pkg.sv
// rtl/uno_pkg.sv - shared types, card constants and helpers for the UNO turn scheduler
package uno_pkg;

    localparam int         N_PLAYERS  = 4;
    localparam logic [6:0] DRAW_SLOT  = 7'd108;
    localparam logic [5:0] EMPTY_CARD = 6'h3F;

    localparam logic [3:0] VAL_SKIP    = 4'd10;
    localparam logic [3:0] VAL_REVERSE = 4'd11;
    localparam logic [3:0] VAL_DRAW2   = 4'd12;
    localparam logic [3:0] VAL_WILD    = 4'd13;
    localparam logic [3:0] VAL_WILD4   = 4'd14;

    typedef struct packed {
        logic [1:0] color;
        logic [3:0] value;
    } card_t;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_TURN_START = 4'd1,
        ST_HUMAN_WAIT = 4'd2,
        ST_COLOR_SEL  = 4'd3,
        ST_COM_WAIT   = 4'd4,
        ST_EFFECT     = 4'd5,
        ST_DRAW       = 4'd6,
        ST_ADVANCE    = 4'd7,
        ST_END        = 4'd8
    } state_e;

    function automatic logic is_wild(card_t c);
        return c.value >= VAL_WILD;
    endfunction

    function automatic logic is_legal(card_t c, logic [1:0] color, card_t prev);
        return is_wild(c) || (c.color == color) || (c.value == prev.value);
    endfunction

    // Seat arithmetic wraps naturally in 2 bits; dir=1 walks counter-clockwise.
    function automatic logic [1:0] advance(logic [1:0] p, logic dir, logic [1:0] k);
        return dir ? (p - k) : (p + k);
    endfunction

endpackage

// File: rtl/uno_cursor.sv
// rtl/uno_cursor.sv - human hand cursor with wrap through the draw-pile slot
// Ports: i_clk/i_rst_n clock and async active-low reset; i_init reloads the
// cursor for a new human turn; i_en enables left/right moves; i_hand_n is the
// human card count; o_index is the cursor (DRAW_SLOT = draw pile selected).
module uno_cursor
    import uno_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_init,
    input  logic       i_en,
    input  logic       i_left,
    input  logic       i_right,
    input  logic [6:0] i_hand_n,
    output logic [6:0] o_index
);

    logic [6:0] idx_q;
    logic [6:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (i_init) begin
            idx_d = (i_hand_n != 7'd0) ? 7'd0 : DRAW_SLOT;
        end else if (i_en && (i_left ^ i_right)) begin
            if (i_right) begin
                if (idx_q == DRAW_SLOT)
                    idx_d = (i_hand_n != 7'd0) ? 7'd0 : DRAW_SLOT;
                // ">=" also covers an empty hand and a hand that shrank under the cursor
                else if (idx_q + 7'd1 >= i_hand_n)
                    idx_d = DRAW_SLOT;
                else
                    idx_d = idx_q + 7'd1;
            end else begin
                if (idx_q == DRAW_SLOT)
                    idx_d = (i_hand_n != 7'd0) ? (i_hand_n - 7'd1) : DRAW_SLOT;
                else if (idx_q == 7'd0)
                    idx_d = DRAW_SLOT;
                else
                    idx_d = idx_q - 7'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) idx_q <= 7'd0;
        else          idx_q <= idx_d;
    end

    assign o_index = idx_q;

endmodule

// File: rtl/uno_turn_sched.sv
// rtl/uno_turn_sched.sv - 4-player UNO turn scheduler (human keys, COM handshake, deck draws)
// Ports: game control i_start/i_first_card; human keys i_left/i_right/i_select with
// i_cur_card; i_hand_num packs seat s count at [7s+6:7s]; COM handshake o_com_req /
// i_com_valid/i_com_pass/i_com_card/i_com_idx/i_com_color; deck o_draw_req/i_draw_ack/
// o_draw_player; play strobe o_play_*; display state o_index/o_prev_card/o_color/
// o_player/o_dir/o_select_color/o_illegal/o_end/o_state.
// Build option: UNO_COM_TIMEOUT_EN adds a COM reply timeout (COM_TIMEOUT cycles).
module uno_turn_sched
    import uno_pkg::*;
`ifdef UNO_COM_TIMEOUT_EN
#(
    parameter int COM_TIMEOUT = 20000
)
`endif
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [5:0]  i_first_card,
    input  logic        i_left,
    input  logic        i_right,
    input  logic        i_select,
    input  logic [5:0]  i_cur_card,
    input  logic [N_PLAYERS*7-1:0] i_hand_num,
    output logic        o_com_req,
    input  logic        i_com_valid,
    input  logic        i_com_pass,
    input  logic [5:0]  i_com_card,
    input  logic [6:0]  i_com_idx,
    input  logic [1:0]  i_com_color,
    output logic        o_draw_req,
    input  logic        i_draw_ack,
    output logic [1:0]  o_draw_player,
    output logic        o_play_valid,
    output logic [1:0]  o_play_player,
    output logic [6:0]  o_play_idx,
    output logic [5:0]  o_play_card,
    output logic [6:0]  o_index,
    output logic [5:0]  o_prev_card,
    output logic [1:0]  o_color,
    output logic [1:0]  o_player,
    output logic        o_dir,
    output logic        o_select_color,
    output logic        o_illegal,
    output logic        o_end,
    output logic [3:0]  o_state
);

    state_e     state_q, state_d;
    logic [1:0] player_q, player_d;
    logic       dir_q, dir_d;
    logic [1:0] color_q, color_d;
    card_t      prev_q, prev_d;
    logic [2:0] pending_q, pending_d;
    logic [1:0] cand_q, cand_d;
    logic       last_q, last_d;
    logic       play_valid_q, play_valid_d;
    logic [1:0] play_player_q, play_player_d;
    logic [6:0] play_idx_q, play_idx_d;
    logic [5:0] play_card_q, play_card_d;
    logic       illegal_q, illegal_d;

    card_t      hum_card, com_card;
    logic [6:0] cur_hand_n;
    logic       cursor_init, cursor_en;

    assign hum_card   = card_t'(i_cur_card);
    assign com_card   = card_t'(i_com_card);
    assign cur_hand_n = i_hand_num[7*player_q +: 7];

    assign cursor_init = (state_q == ST_TURN_START) && (pending_q == 3'd0) && (player_q == 2'd0);
    assign cursor_en   = (state_q == ST_HUMAN_WAIT) && !i_select;

    uno_cursor u_cursor (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_init   (cursor_init),
        .i_en     (cursor_en),
        .i_left   (i_left),
        .i_right  (i_right),
        .i_hand_n (i_hand_num[6:0]),
        .o_index  (o_index)
    );

`ifdef UNO_COM_TIMEOUT_EN
    logic [31:0] cnt_q;
    logic        com_timeout;
    // Held at zero outside COM_WAIT, so every entry starts a fresh count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                    cnt_q <= 32'd0;
        else if (state_q == ST_COM_WAIT) cnt_q <= cnt_q + 32'd1;
        else                             cnt_q <= 32'd0;
    end
    assign com_timeout = (cnt_q >= 32'(COM_TIMEOUT - 1));
`else
    logic com_timeout;
    assign com_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            player_q      <= 2'd0;
            dir_q         <= 1'b0;
            color_q       <= 2'd0;
            prev_q        <= '0;
            pending_q     <= 3'd0;
            cand_q        <= 2'd0;
            last_q        <= 1'b0;
            play_valid_q  <= 1'b0;
            play_player_q <= 2'd0;
            play_idx_q    <= 7'd0;
            play_card_q   <= 6'd0;
            illegal_q     <= 1'b0;
        end else begin
            player_q      <= player_d;
            dir_q         <= dir_d;
            color_q       <= color_d;
            prev_q        <= prev_d;
            pending_q     <= pending_d;
            cand_q        <= cand_d;
            last_q        <= last_d;
            play_valid_q  <= play_valid_d;
            play_player_q <= play_player_d;
            play_idx_q    <= play_idx_d;
            play_card_q   <= play_card_d;
            illegal_q     <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        player_d      = player_q;
        dir_d         = dir_q;
        color_d       = color_q;
        prev_d        = prev_q;
        pending_d     = pending_q;
        cand_d        = cand_q;
        last_d        = last_q;
        play_valid_d  = 1'b0;
        play_player_d = play_player_q;
        play_idx_d    = play_idx_q;
        play_card_d   = play_card_q;
        illegal_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_END: begin
                if (i_start) begin
                    prev_d    = card_t'(i_first_card);
                    color_d   = i_first_card[5:4];
                    player_d  = 2'd0;
                    dir_d     = 1'b0;
                    pending_d = 3'd0;
                    state_d   = ST_TURN_START;
                end
            end
            ST_TURN_START: begin
                if (pending_q != 3'd0)      state_d = ST_DRAW;
                else if (player_q == 2'd0)  state_d = ST_HUMAN_WAIT;
                else                        state_d = ST_COM_WAIT;
            end
            ST_HUMAN_WAIT: begin
                if (i_select) begin
                    if (o_index == DRAW_SLOT) begin
                        pending_d = 3'd1;
                        state_d   = ST_DRAW;
                    end else if (!is_legal(hum_card, color_q, prev_q)) begin
                        illegal_d = 1'b1;
                    end else begin
                        play_valid_d  = 1'b1;
                        play_player_d = player_q;
                        play_idx_d    = o_index;
                        play_card_d   = i_cur_card;
                        prev_d        = hum_card;
                        last_d        = (cur_hand_n == 7'd1);
                        if (is_wild(hum_card)) begin
                            cand_d  = 2'd0;
                            state_d = ST_COLOR_SEL;
                        end else begin
                            color_d = hum_card.color;
                            state_d = (cur_hand_n == 7'd1) ? ST_END : ST_EFFECT;
                        end
                    end
                end
            end
            ST_COLOR_SEL: begin
                if (i_select) begin
                    color_d = cand_q;
                    state_d = last_q ? ST_END : ST_EFFECT;
                end else if (i_right && !i_left) begin
                    cand_d = cand_q + 2'd1;
                end else if (i_left && !i_right) begin
                    cand_d = cand_q - 2'd1;
                end
            end
            ST_COM_WAIT: begin
                if (i_com_valid) begin
                    if (i_com_pass) begin
                        pending_d = 3'd1;
                        state_d   = ST_DRAW;
                    end else begin
                        play_valid_d  = 1'b1;
                        play_player_d = player_q;
                        play_idx_d    = i_com_idx;
                        play_card_d   = i_com_card;
                        prev_d        = com_card;
                        color_d       = is_wild(com_card) ? i_com_color : com_card.color;
                        state_d       = (cur_hand_n == 7'd1) ? ST_END : ST_EFFECT;
                    end
                end else if (com_timeout) begin
                    pending_d = 3'd1;
                    state_d   = ST_DRAW;
                end
            end
            ST_EFFECT: begin
                state_d = ST_TURN_START;
                case (prev_q.value)
                    VAL_SKIP:    player_d = advance(player_q, dir_q, 2'd2);
                    VAL_REVERSE: begin
                        dir_d    = ~dir_q;
                        player_d = advance(player_q, ~dir_q, 2'd1);
                    end
                    VAL_DRAW2: begin
                        pending_d = 3'd2;
                        player_d  = advance(player_q, dir_q, 2'd1);
                    end
                    VAL_WILD4: begin
                        pending_d = 3'd4;
                        player_d  = advance(player_q, dir_q, 2'd1);
                    end
                    default:     player_d = advance(player_q, dir_q, 2'd1);
                endcase
            end
            ST_DRAW: begin
                if (pending_q == 3'd0) begin
                    state_d = ST_ADVANCE;
                end else if (i_draw_ack) begin
                    pending_d = pending_q - 3'd1;
                    if (pending_q == 3'd1) state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                player_d = advance(player_q, dir_q, 2'd1);
                state_d  = ST_TURN_START;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_com_req      = (state_q == ST_COM_WAIT);
        o_draw_req     = (state_q == ST_DRAW);
        o_select_color = (state_q == ST_COLOR_SEL);
        o_end          = (state_q == ST_END);
        o_state        = state_q;
    end

    // Every draw goes to the seat whose turn it currently is.
    assign o_draw_player = player_q;
    assign o_play_valid  = play_valid_q;
    assign o_play_player = play_player_q;
    assign o_play_idx    = play_idx_q;
    assign o_play_card   = play_card_q;
    assign o_prev_card   = prev_q;
    assign o_color       = color_q;
    assign o_player      = player_q;
    assign o_dir         = dir_q;
    assign o_illegal     = illegal_q;

endmodule

// File: doc/uno_turn_sched.md
Name: uno_turn_sched

Overview:
- Turn scheduler for the 4-player UNO game.
- Owns the current player, play direction, active colour, last played card, the human cursor index and the pending-draw count.
- Sequences the human (KEY pulses), the three COM engines (request/valid handshake) and the deck (draw request/ack).
- Feeds the hand store and the VGA display logic.

Parameters:
- N_PLAYERS, 4, number of seats; the human is seat 0.
- DRAW_SLOT, 108, cursor value meaning "draw pile selected".
- COM_TIMEOUT, 20000, cycles to wait for a COM reply (optional feature only).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse; starts a game from IDLE
- i_first_card  in  6  first discard; sampled on i_start
- i_left / i_right / i_select  in  1 each  debounced one-cycle key pulses
- i_cur_card  in  6  card at hands[o_index] of seat 0; combinational from hand store
- i_hand_num  in  4x7  card count per seat
- o_com_req  out  1  level; asks COM o_player for a move
- i_com_valid  in  1  one-cycle reply strobe
- i_com_pass  in  1  COM chooses to draw
- i_com_card  in  6  card played by COM
- i_com_idx  in  7  hand index of that card
- i_com_color  in  2  colour chosen for a wild
- o_draw_req  out  1  level; deck deals one card to o_draw_player
- i_draw_ack  in  1  one card dealt
- o_draw_player  out  2  seat receiving the card
- o_play_valid  out  1  one-cycle pulse; a card was played
- o_play_player  out  2  seat that played
- o_play_idx  out  7  hand index of the played card
- o_play_card  out  6  card played
- o_index  out  7  cursor
- o_prev_card  out  6  last played card
- o_color  out  2  active colour
- o_player  out  2  seat whose turn it is
- o_dir  out  1  0 = clockwise (+1), 1 = counter-clockwise
- o_select_color  out  1  high in COLOR_SEL
- o_illegal  out  1  one-cycle pulse on a rejected human select
- o_end  out  1  game over
- o_state  out  4  FSM state, drives the HEX debug display

Behaviour:
- Card encoding: [5:4] colour, [3:0] value. Values 0-9 are numbers; 10 skip; 11 reverse; 12 draw-two; 13 wild; 14 wild-draw-four. 6'h3F = empty.
- Legal play: value ≥ 13, or colour == o_color, or value == o_prev_card[3:0].
- Reset values: FSM IDLE. o_index = 0, o_prev_card = 0, o_color = 0, o_player = 0, o_dir = 0. All strobes, requests and o_end = 0.
- IDLE: on i_start, load prev_card = i_first_card and color = i_first_card[5:4]; player = 0, dir = 0, pending = 0; go to TURN_START.
- TURN_START (1 cycle):
  - If pending > 0, go to DRAW with target = player.
  - Else if player == 0: cursor = 0 if i_hand_num[0] > 0, else DRAW_SLOT; go to HUMAN_WAIT.
  - Else go to COM_WAIT.
- HUMAN_WAIT:
  - i_select has priority over moves in the same cycle. i_left and i_right together are ignored.
  - i_right: DRAW_SLOT → 0; n−1 → DRAW_SLOT; otherwise +1.
  - i_left: DRAW_SLOT → n−1 (stays at DRAW_SLOT if n = 0); 0 → DRAW_SLOT; otherwise −1.
  - i_select on DRAW_SLOT: pending = 1, target = 0, go to DRAW, then ADVANCE by 1.
  - i_select on an illegal card: pulse o_illegal, stay.
  - i_select on a legal card: pulse o_play_valid, then go to EFFECT, or to COLOR_SEL if the card is wild.
- COLOR_SEL:
  - i_right increments the candidate colour mod 4; i_left decrements it mod 4.
  - i_select commits the colour and goes to EFFECT.
- COM_WAIT:
  - o_com_req is held high until i_com_valid.
  - Pass: handled as a human draw.
  - Card: pulse o_play_valid. For a wild, color = i_com_color. Go to EFFECT.
  - The controller does not recheck COM cards for legality.
- Play bookkeeping: on o_play_valid, prev_card = card. If i_hand_num[player] == 1, go to END instead of EFFECT.
- EFFECT:
  - Skip: advance by 2.
  - Reverse: toggle dir, advance by 1.
  - Draw-two / wild-draw-four: pending = 2 / 4 for the next seat, then TURN_START for that seat. That seat draws and is then skipped (DRAW → ADVANCE by 1).
  - Others: advance by 1.
- Advance arithmetic: player = (player ± k) mod 4 in 2-bit wrap.
- DRAW: o_draw_req is held high. Each i_draw_ack decrements pending; at 0 go to ADVANCE. An ack arriving with pending already 0 is ignored.
- END: o_end = 1, all requests low, keys ignored; leave only on i_start (new game) or reset.
- Reset mid-operation returns to IDLE immediately; outstanding COM/deck requests drop that cycle.

Optional Feature:
- UNO_COM_TIMEOUT_EN defined: a counter runs in COM_WAIT. After COM_TIMEOUT cycles with no i_com_valid, the turn is treated as a pass: draw 1, then advance. The counter clears on every entry to COM_WAIT.
- Undefined: COM_WAIT waits indefinitely and no counter exists.

Decomposition:
- Package uno_pkg: card typedef (colour/value struct), value constants (SKIP = 10 … WILD4 = 14), EMPTY_CARD = 6'h3F, DRAW_SLOT, and the FSM state enum.
- One sub-module, uno_cursor: the wrap-around cursor logic. Inputs: hand count and left/right pulses. Output: index.

Test Plan:
- First card 6'h05 (colour 0, value 5); human plays 6'h15 (colour 1, 5) → legal. o_play_valid=1, o_color=1, o_player 0→1.
- Human has 3 cards, cursor at 2, i_right → o_index=108. i_right → 0. i_left from 0 → 108.
- Human selects card 6'h27 against prev 6'h05 → o_illegal pulse; state and player unchanged.
- COM 1 plays 6'h0C (draw-two) → seat 2 receives 2 o_draw_req/i_draw_ack cycles, then o_player=3.
- Reverse played by seat 0 → o_dir=1, next o_player=3. A skip follows → o_player=1.
- Human plays wild 6'h0D; i_right×2, i_select → o_color=2, o_select_color cleared. With i_hand_num[0]=1 → o_end=1.
